timer_counter: RTL and testbench



---
 rtl/timer_counter_pkg.sv | 27 ++
 rtl/timer_counter_if.sv | 14 +
 rtl/timer_counter.sv | 114 +++++++++++
 tb/tb_timer_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared timer definitions: base addresses, register offsets, CTRL bit fields,
// mode encodings and FSM state encodings.
package timer_counter_pkg;

    localparam logic [31:0] TIMER0_BASE = 32'h0000_1000;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_1010;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of one timer instance: address, write strobe/data in,
// combinational read data and interrupt out.
interface timer_counter_if #(
    parameter int CNT_W = 32
) ();
    logic [31:0]      addr;
    logic             we;
    logic [CNT_W-1:0] din;
    logic [CNT_W-1:0] dout;
    logic             irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with one-shot / periodic modes and a maskable
// interrupt. Bus writes take priority and freeze the FSM for that cycle.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irq_flag;

    state_e           w_state_next;
    logic [3:0]       w_ctrl_next;
    logic [CNT_W-1:0] w_preset_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_irq_next;

    logic             w_en;
    logic [1:0]       w_mode;
    logic [1:0]       w_offset;
    logic             w_unused_addr;

    assign w_en          = r_ctrl[CTRL_EN];
    assign w_mode        = r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign w_offset      = bus.addr[3:2];
    assign w_unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    always_comb begin
        w_state_next  = r_state;
        w_ctrl_next   = r_ctrl;
        w_preset_next = r_preset;
        w_count_next  = r_count;
        w_irq_next    = r_irq_flag;
        if (bus.we) begin
            case (w_offset)
                REG_CTRL:   w_ctrl_next   = bus.din[3:0];
                REG_PRESET: w_preset_next = bus.din;
                default:    ;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_en) begin
                        w_irq_next   = 1'b0;
                        w_state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_count_next = r_preset;
                    w_state_next = ST_CNT;
                end
                ST_CNT: begin
                    if (!w_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_count > ONE) begin
                        w_count_next = r_count - ONE;
                    end else begin
                        // Saturate at zero: PRESET=0 expires like PRESET=1.
                        w_count_next = '0;
                        w_irq_next   = 1'b1;
                        w_state_next = ST_INT;
                    end
                end
                default: begin
                    if (w_mode == MODE_PERIODIC) begin
                        w_irq_next = 1'b0;
                    end else begin
                        w_ctrl_next[CTRL_EN] = 1'b0;
                    end
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl     <= w_ctrl_next;
            r_preset   <= w_preset_next;
            r_count    <= w_count_next;
            r_irq_flag <= w_irq_next;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (w_offset)
            REG_CTRL:   bus.dout = {{(CNT_W-4){1'b0}}, r_ctrl};
            REG_PRESET: bus.dout = r_preset;
            REG_COUNT:  bus.dout = r_count;
            default:    bus.dout = '0;
        endcase
    end

    // The flag keeps tracking while masked; IM only gates the pin.
    assign bus.irq = r_ctrl[CTRL_IM] & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a vector table for reset/one-shot plus
// hand-written sequences for periodic, boundary, masking, stall and disable.
module tb_timer_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    timer_counter_if #(.CNT_W(32)) bus ();

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] din;
        logic [1:0]  rd;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: present inputs, take the edge, then select rd for readback.
    task automatic cyc(input logic we, input logic [1:0] off, input logic [31:0] din,
                       input logic [1:0] rd);
        bus.we   = we;
        bus.addr = {28'd0, off, 2'b00};
        bus.din  = din;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        bus.addr = {28'd0, rd, 2'b00};
        bus.din  = '0;
        #1;
        if (we) $display("t=%0t write off=%0d data=0x%0h", $time, off, din);
    endtask

    task automatic do_reset();
        bus.we = 1'b0; bus.addr = '0; bus.din = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_periodic(input logic [31:0] p);
        int peff;
        int ph;
        logic [31:0] ec;
        logic ei;
        peff = (p == 0) ? 1 : int'(p);
        do_reset();
        cyc(1'b1, 2'd1, p, 2'd2);
        cyc(1'b1, 2'd0, 32'hB, 2'd2);
        for (int k = 1; k <= 4 * (peff + 3) + 1; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            ph = (k - 2) % (peff + 3);
            ec = 32'd0;
            ei = 1'b0;
            if (k >= 2 && ph < peff) ec = (p == 0) ? 32'd0 : p - 32'(ph);
            if (k >= 2 && ph == peff) ei = 1'b1;
            $display("periodic P=%0d k=%0d count=%0d irq=%0b", p, k, bus.dout, bus.irq);
            check("periodic_count", bus.dout, ec);
            check("periodic_irq", {31'd0, bus.irq}, {31'd0, ei});
        end
    endtask

    initial begin
        // Reset reads, then one-shot PRESET=3 CTRL=0x9, edge-by-edge.
        tbl[0]  = '{1'b0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 32'd0, 2'd1, 32'd0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd0, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 32'd3, 2'd1, 32'd3, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 32'h9, 2'd0, 32'h9, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b1};
        tbl[12] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].we, tbl[i].off, tbl[i].din, tbl[i].rd);
            $display("vec %0d rd=%0d dout=0x%0h irq=%0b", i, tbl[i].rd, bus.dout, bus.irq);
            check($sformatf("vec%0d_dout", i), bus.dout, tbl[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].exp_irq});
        end

        // Sticky one-shot irq, cleared only after CTRL rewrite passes IDLE.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd0);
            check("oneshot_sticky", {31'd0, bus.irq}, 32'd1);
        end
        cyc(1'b1, 2'd0, 32'h9, 2'd0);
        check("rearm_write_cycle_irq", {31'd0, bus.irq}, 32'd1);
        cyc(1'b0, 2'd0, 32'd0, 2'd0);
        check("rearm_irq_drop", {31'd0, bus.irq}, 32'd0);

        run_periodic(32'd3);
        run_periodic(32'd0);

        // Masked one-shot, then unmask with EN=0.
        do_reset();
        cyc(1'b1, 2'd1, 32'd2, 2'd0);
        cyc(1'b1, 2'd0, 32'h1, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd0);
            check("masked_irq", {31'd0, bus.irq}, 32'd0);
        end
        check("masked_en_cleared", bus.dout, 32'd0);
        cyc(1'b1, 2'd0, 32'h8, 2'd0);
        check("unmask_irq", {31'd0, bus.irq}, 32'd1);

        // COUNT write ignored and stalls decrement one cycle.
        do_reset();
        cyc(1'b1, 2'd1, 32'd5, 2'd2);
        cyc(1'b1, 2'd0, 32'h9, 2'd2);
        repeat (3) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("stall_pre", bus.dout, 32'd4);
        cyc(1'b1, 2'd2, 32'h55, 2'd2);
        check("stall_write", bus.dout, 32'd4);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("stall_resume", bus.dout, 32'd3);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("stall_next", bus.dout, 32'd2);

        // Disable mid-count, freeze, re-enable reloads.
        do_reset();
        cyc(1'b1, 2'd1, 32'd10, 2'd2);
        cyc(1'b1, 2'd0, 32'h9, 2'd2);
        repeat (6) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("dis_at6", bus.dout, 32'd6);
        cyc(1'b1, 2'd0, 32'h8, 2'd2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            check("dis_frozen", bus.dout, 32'd6);
            check("dis_irq", {31'd0, bus.irq}, 32'd0);
        end
        cyc(1'b1, 2'd0, 32'h9, 2'd2);
        repeat (2) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("reenable_reload", bus.dout, 32'd10);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        check("reenable_dec", bus.dout, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
